// File: rtl/dypat_pkg.sv
// Shared definitions for the dynamic pattern detector link: the generator
// state encoding and the default widths used by dypat and its benches.
package dypat_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam int DEFAULT_W  = 4;
   localparam int DEFAULT_CW = 8;
   localparam int DEFAULT_GW = 4;

endpackage

// File: rtl/dypat_gen.sv
// Serial pattern generator: captures a W-bit pattern and sends it MSB-first
// reps times, with an optional idle gap between copies. All outputs registered.
module dypat_gen
   import dypat_pkg::*;
#(
   parameter int W  = DEFAULT_W,
   parameter int CW = DEFAULT_CW,
   parameter int GW = DEFAULT_GW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  pat,
   input  logic [CW-1:0] reps,
   input  logic [GW-1:0] gap,
   output logic          busy,
   output logic          out,
   output logic          valid,
   output logic          done,
   output logic [CW-1:0] sent
);

   localparam int IW = (W > 1) ? $clog2(W) : 1;
   localparam logic [IW-1:0] IDX_MSB = IW'(W - 1);

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [GW-1:0] gapCnt_q, gapCnt_d;
   logic [W-1:0]  pat_q, pat_d;
   logic [CW-1:0] reps_q, reps_d;
   logic [GW-1:0] gapLen_q, gapLen_d;
   logic [CW-1:0] sent_q, sent_d;
   logic          out_q, out_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [CW-1:0] sentInc;

   // Output registers are loaded with the value for the state being entered,
   // so idx_q always names the bit currently on out.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      gapCnt_d = gapCnt_q;
      pat_d    = pat_q;
      reps_d   = reps_q;
      gapLen_d = gapLen_q;
      sent_d   = sent_q;
      out_d    = 1'b0;
      valid_d  = 1'b0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      sentInc  = sent_q + 1'b1;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               pat_d    = pat;
               reps_d   = reps;
               gapLen_d = gap;
               idx_d    = IDX_MSB;
               gapCnt_d = '0;
               sent_d   = '0;
               busy_d   = 1'b1;
               if (reps == '0) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = SEND;
                  out_d   = pat[W-1];
                  valid_d = 1'b1;
               end
            end
         end

         SEND: begin
            if (idx_q != '0) begin
               idx_d   = idx_q - 1'b1;
               out_d   = pat_q[idx_d];
               valid_d = 1'b1;
            end else begin
               // sent never passes reps, so equality is the final-copy test
               sent_d = sentInc;
               if (sentInc == reps_q) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else if (gapLen_q != '0) begin
                  state_d  = GAP;
                  gapCnt_d = gapLen_q - 1'b1;
               end else begin
                  idx_d   = IDX_MSB;
                  out_d   = pat_q[W-1];
                  valid_d = 1'b1;
               end
            end
         end

         GAP: begin
            if (gapCnt_q == '0) begin
               state_d = SEND;
               idx_d   = IDX_MSB;
               out_d   = pat_q[W-1];
               valid_d = 1'b1;
            end else begin
               gapCnt_d = gapCnt_q - 1'b1;
            end
         end

         FIN: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         gapCnt_q <= '0;
         pat_q    <= '0;
         reps_q   <= '0;
         gapLen_q <= '0;
         sent_q   <= '0;
         out_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         gapCnt_q <= gapCnt_d;
         pat_q    <= pat_d;
         reps_q   <= reps_d;
         gapLen_q <= gapLen_d;
         sent_q   <= sent_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy  = busy_q;
   assign out   = out_q;
   assign valid = valid_q;
   assign done  = done_q;
   assign sent  = sent_q;

endmodule

// File: doc/dypat_gen.md
# dypat_gen

Serial pattern generator that drives the 1-bit input of the dynamic pattern detector (`dypat`). It captures a W-bit pattern at run time and transmits it MSB-first, a programmable number of times, with an optional idle gap between copies. It is the stimulus and transmit side of the detector link, used in loopback benches and as a synthesizable traffic source.

## Interface
Parameters:
- `W`, 4: pattern width in bits (≥2).
- `CW`, 8: width of repeat count and sent counter.
- `GW`, 4: width of gap length.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `pat`  in  W  pattern, captured on an accepted `start`.
- `reps`  in  CW  number of copies to send, captured with `pat`.
- `gap`  in  GW  idle cycles between copies, captured with `pat`.
- `busy`  out  1  high from the cycle after acceptance through the `done` cycle.
- `out`  out  1  serial data bit.
- `valid`  out  1  high while `out` carries a pattern bit.
- `done`  out  1  one-cycle completion pulse.
- `sent`  out  CW  copies fully transmitted since the last accepted `start`.

## Operation
- All outputs are registered. On reset, every output is 0 (`busy`, `out`, `valid`, `done`, `sent`) and the state is IDLE.
- States:
  - **IDLE**: `start`=1 is accepted. `pat`, `reps`, and `gap` are latched. Bit index is set to W-1, the gap counter is cleared, and `sent` is cleared to 0. If `reps`=0, go to FIN; otherwise go to SEND.
  - **SEND**: `out` = latched pat[idx] and `valid`=1. Index decrements each cycle. On the last bit (idx=0), `sent` increments. Then:
    - If copies remain and `gap`>0, go to GAP.
    - If copies remain and `gap`=0, stay in SEND with idx reloaded to W-1 (back-to-back copies).
    - If no copies remain, go to FIN.
  - **GAP**: `out`=0, `valid`=0, held for exactly `gap` cycles, then SEND with idx=W-1.
  - **FIN**: `done`=1, `valid`=0, `out`=0, `busy`=1 for one cycle, then IDLE.
- `start` is ignored in SEND, GAP, and FIN. Changes on `pat`, `reps`, or `gap` while `busy`=1 have no effect.
- `sent` holds its final value in IDLE until the next accepted `start`. It never exceeds `reps`, so it cannot overflow.
- `out` is 0 whenever `valid`=0. A detector without a valid input therefore sees 0s during gaps and idle.
- Asserting reset mid-operation immediately zeroes all outputs, aborts the transfer, and emits no `done`.

## Timing
- Let t0 be the edge that samples `start`=1 in IDLE.
- First pattern bit (MSB) appears on `out` in the cycle after t0, with `busy`=1.
- Copy k (0-based) occupies cycles 1 + k·(W+gap) through k·(W+gap) + W.
- `sent` becomes k+1 in the cycle after the last bit of copy k.
- `done` occurs in cycle reps·W + (reps−1)·gap + 1. For `reps`=0, `done` occurs in cycle 1.
- `busy` falls in the cycle after `done`. A new `start` may be sampled on that same edge's following cycle, i.e. the earliest is the first cycle with `busy`=0. The minimum idle spacing between transfers is one cycle.

## Structure
- Package `dypat_pkg` holds:
  - the state enum (IDLE, SEND, GAP, FIN), 2-bit encoding;
  - default localparams for W, CW, GW, shared with `dypat` benches.
- Single module. Shift/index logic and the gap counter are inline; no sub-module is required.

## Test plan
- W=4, pat=1011, reps=1, gap=0 → `out` 1,0,1,1 with `valid`=1 in cycles 1–4; `sent`=1 in cycle 5; `done` in cycle 5; `busy`=0 in cycle 6.
- pat=1101, reps=3, gap=0 → 12 contiguous valid bits 110111011101; `sent` reads 1, 2, 3 from cycles 5, 9, 13; `done` in cycle 13. In loopback into `dypat` programmed for 1101, the detector count matches the expected overlap/non-overlap hits.
- pat=1010, reps=2, gap=2 → cycles 1–4 = 1010 valid; cycles 5–6 `out`=0 and `valid`=0; cycles 7–10 = 1010 valid; `done` in cycle 11.
- reps=0, pat=1111 → `valid` never asserted; `done` in cycle 1; `sent`=0.
- `start` pulsed, and `pat` changed to 0000, during cycles 2–6 of a reps=2 pat=1001 transfer → output stream is exactly 10011001 and only one `done` occurs.
- Reset asserted asynchronously (mid-cycle) during copy 2 of reps=3 → `out`, `valid`, `busy`, `sent`, and `done` go to 0 immediately with no `done` pulse; a fresh `start` after release transmits normally from the MSB.
